// File: rtl/clk_gate_pkg.sv
// Shared types for the clock-gate enable controller.
package clk_gate_pkg;

    typedef enum logic [1:0] {
        CG_RUN,
        CG_OFF,
        CG_WAKE
    } cg_state_t;

endpackage

// File: rtl/clk_gate_ctrl_if.sv
// Activity/wake inputs and gate-enable/status outputs of the clock-gate controller.
interface clk_gate_ctrl_if #(
    parameter int STAT_W = 16
);
    logic              busy;
    logic              wake_req;
    logic              force_on;
    logic              clk_en;
    logic              gated;
    logic              wake_ack;
    logic [STAT_W-1:0] gate_count;

    modport master (
        input  busy,
        input  wake_req,
        input  force_on,
        output clk_en,
        output gated,
        output wake_ack,
        output gate_count
    );

    modport slave (
        output busy,
        output wake_req,
        output force_on,
        input  clk_en,
        input  gated,
        input  wake_ack,
        input  gate_count
    );
endinterface

// File: rtl/clk_gate_idle_timer.sv
// Counts consecutive idle cycles while running; pulses expire on the cycle that
// completes IDLE_CYCLES of them.
module clk_gate_idle_timer #(
    parameter int IDLE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic idle,
    output logic expire
);
    localparam int CNT_W = $clog2(IDLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(IDLE_CYCLES - 1);

    generate
        if (IDLE_CYCLES < 1) begin : g_bad_idle_cycles
            $error("clk_gate_idle_timer: IDLE_CYCLES must be >= 1");
        end
    endgenerate

    logic [CNT_W-1:0] idle_cnt;

    assign expire = enable & idle & (idle_cnt == LAST);

    // Any non-idle cycle, leaving RUN, or firing restarts the streak.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt <= '0;
        end else if (!enable || !idle || expire) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/clk_gate_ctrl.sv
// Drives the enable of a latch-based clock gate: gates after an idle streak,
// ungates on wake request or force-on with a settle period before acknowledging.
module clk_gate_ctrl
    import clk_gate_pkg::*;
#(
    parameter int IDLE_CYCLES = 16,
    parameter int WAKE_CYCLES = 2,
    parameter int STAT_W      = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    clk_gate_ctrl_if.master        cg
);
    localparam int WCNT_W = $clog2(WAKE_CYCLES + 1);
    localparam logic [WCNT_W-1:0] WAKE_LOAD = WCNT_W'(WAKE_CYCLES - 1);

    generate
        if (WAKE_CYCLES < 1) begin : g_bad_wake_cycles
            $error("clk_gate_ctrl: WAKE_CYCLES must be >= 1");
        end
    endgenerate

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    cg_state_t         state_q, state_d;
    logic              clk_en_q, clk_en_d;
    logic              gated_q, gated_d;
    logic              wake_ack_q, wake_ack_d;
    logic [STAT_W-1:0] gate_count_q, gate_count_d;
    logic [WCNT_W-1:0] wake_cnt_q, wake_cnt_d;
    logic              idle;
    logic              expire;

    assign idle = ~(cg.busy | cg.wake_req | cg.force_on);

    clk_gate_idle_timer #(
        .IDLE_CYCLES (IDLE_CYCLES)
    ) u_idle_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (state_q == CG_RUN),
        .idle   (idle),
        .expire (expire)
    );

    always_comb begin
        state_d      = state_q;
        clk_en_d     = clk_en_q;
        gated_d      = gated_q;
        wake_cnt_d   = wake_cnt_q;
        gate_count_d = gate_count_q;
        // Four-phase ack: only raised from RUN, held while the request stays up.
        wake_ack_d   = cg.wake_req & (wake_ack_q | (state_q == CG_RUN));

        case (state_q)
            CG_RUN: begin
                clk_en_d = 1'b1;
                gated_d  = 1'b0;
                if (expire) begin
                    state_d      = CG_OFF;
                    clk_en_d     = 1'b0;
                    gated_d      = 1'b1;
                    gate_count_d = sat_inc(gate_count_q);
                end
            end
            CG_OFF: begin
                clk_en_d = 1'b0;
                gated_d  = 1'b1;
                if (!idle) begin
                    state_d    = CG_WAKE;
                    clk_en_d   = 1'b1;
                    gated_d    = 1'b0;
                    wake_cnt_d = WAKE_LOAD;
                end
            end
            CG_WAKE: begin
                clk_en_d = 1'b1;
                gated_d  = 1'b0;
                if (wake_cnt_q == '0) begin
                    state_d = CG_RUN;
                end else begin
                    wake_cnt_d = wake_cnt_q - 1'b1;
                end
            end
            default: begin
                state_d  = CG_RUN;
                clk_en_d = 1'b1;
                gated_d  = 1'b0;
            end
        endcase
    end

    // Reset asserts clk_en immediately so a gated domain is never left stopped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= CG_RUN;
            clk_en_q     <= 1'b1;
            gated_q      <= 1'b0;
            wake_ack_q   <= 1'b0;
            gate_count_q <= '0;
            wake_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            clk_en_q     <= clk_en_d;
            gated_q      <= gated_d;
            wake_ack_q   <= wake_ack_d;
            gate_count_q <= gate_count_d;
            wake_cnt_q   <= wake_cnt_d;
        end
    end

    assign cg.clk_en     = clk_en_q;
    assign cg.gated      = gated_q;
    assign cg.wake_ack   = wake_ack_q;
    assign cg.gate_count = gate_count_q;

endmodule
